maze_ram_arbiter: RTL and testbench
===================================

Name: maze_ram_arbiter

Overview:
Arbitrates the single-port 24x24 maze cell RAM (3-bit cell codes) among three requesters: the move-legality checker (read), the position updater (write), and the VGA board renderer (read).
Converts (x,y) to a linear address and sequences each access with the RAM's fixed read latency.
Returns data with a one-cycle ack pulse.
Prevents renderer starvation with an aging counter. Sits between the game-logic FSMs/renderer and the maze RAM.

Parameters:
GRID_W, 24, maze columns; valid x 0..GRID_W-1
GRID_H, 24, maze rows; valid y 0..GRID_H-1
READ_LATENCY, 1, RAM cycles from address to valid mem_rdata (>=1)
MAX_WAIT, 8, cycles the renderer may wait before forced grant

Ports:
clock  in  1  system clock
resetn  in  1  synchronous, active-low reset
chk_req  in  1  checker read request, level, held until chk_ack
chk_x, chk_y  in  5 each  checker cell coordinates
chk_ack  out  1  one-cycle pulse, chk_rdata valid
chk_rdata  out  3  cell code read for checker
wr_req  in  1  updater write request, level
wr_x, wr_y  in  5 each  write coordinates
wr_data  in  3  cell code to write
wr_ack  out  1  one-cycle pulse, write committed
drw_req  in  1  renderer read request, level
drw_x, drw_y  in  5 each  renderer coordinates
drw_ack  out  1  one-cycle pulse, drw_rdata valid
drw_rdata  out  3  cell code read for renderer
oob_err  out  1  one-cycle pulse with ack when granted coordinates are out of range
busy  out  1  high in any state other than IDLE
mem_addr  out  10  RAM address = y*GRID_W + x
mem_wren  out  1  RAM write enable
mem_wdata  out  3  RAM write data
mem_rdata  in  3  RAM read data

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; all acks, oob_err, mem_wren 0; mem_addr, mem_wdata, chk_rdata, drw_rdata 0; age 0.
- Reset mid-transaction aborts with no ack. mem_wren is low from the next cycle. Requesters keep req high and are re-served.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Winner rule: if drw_req and age==MAX_WAIT, the drawer wins. Otherwise fixed priority chk > wr > drw.
  - Latch the winner's id, coordinates and data.
  - If x>=GRID_W or y>=GRID_H, go to ACK with oob flag set. Otherwise go to ISSUE. No requests: stay in IDLE.
- ISSUE (1 cycle): drive mem_addr (registered).
  - Write: mem_wren=1 and mem_wdata=wr_data for exactly this cycle, then ACK.
  - Read: mem_wren=0, then WAIT.
- WAIT: lasts READ_LATENCY cycles. On the last cycle, capture mem_rdata into the winner's rdata register, then go to ACK.
- ACK (1 cycle): pulse the winner's ack. Return to IDLE.
  - For oob: pulse oob_err, set rdata to 3'h0 (OCCUPIED). No mem_wren, and mem_addr is unchanged.
- Latency from req first seen in IDLE to ack:
  - Read: 2+READ_LATENCY cycles (3 at default).
  - Write: 2 cycles.
  - Oob: 1 cycle.
- Requester protocol: drop req in the cycle after ack. A req still high in the following IDLE is treated as a new request.
- rdata registers hold their value until the next ack to the same port.
- Address arithmetic: y*24 computed as (y<<4)+(y<<3), zero-extended to 10 bits. Max 575. Address is never formed from out-of-range inputs.
- Aging counter (width clog2(MAX_WAIT+1)):
  - Increments each cycle that drw_req=1 and the drawer is not granted. Saturates at MAX_WAIT.
  - Clears on drawer grant or when drw_req=0.
- Simultaneous events: only one grant per IDLE cycle. Losers keep req and wait. New requests arriving during ISSUE/WAIT/ACK are not sampled until IDLE.
- At most one ack is high in any cycle.

Decomposition:
- Shared package maze_pkg:
  - Cell codes: OCCUPIED=0, AVAILABLE=1, START=2, END=3, YOUR_POSITION=4, PLUS_FIVE=5, MINUS_FIVE=6.
  - GRID_W, GRID_H, ADDR_W=10.
  - Requester ids: REQ_CHK=0, REQ_WR=1, REQ_DRW=2.
  - Arbiter state encoding.
- Sub-module maze_addr_calc: combinational (x,y) -> {addr[9:0], oob}. Reused by the renderer.

Test Plan:
- chk_req at (3,2), RAM returns 3'h1 -> mem_addr=51 in ISSUE, chk_ack pulses 3 cycles after req with chk_rdata=1, oob_err=0.
- wr_req at (23,23), wr_data=3'h4 -> mem_addr=575, mem_wren=1 for exactly one cycle, wr_ack 2 cycles later, no other ack.
- chk_req, wr_req and drw_req asserted in the same cycle, each dropped after its ack -> acks in order chk, wr, drw; never two acks in one cycle.
- chk_req at x=24, y=0 -> chk_ack and oob_err pulse 1 cycle later, chk_rdata=0, mem_wren stays 0, mem_addr unchanged.
- MAX_WAIT=8; drw_req held while chk_req re-asserts immediately after each ack -> drawer granted once age reaches 8, ahead of the pending chk_req. Age returns to 0 after the grant.
- resetn=0 during ISSUE of a write -> mem_wren=0 next cycle, no wr_ack. With wr_req still high after reset release, the write re-executes and wr_ack pulses once.

Source files
------------

// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : maze_pkg
//  Purpose  : Shared definitions for the maze cell RAM and its arbiter:
//             grid geometry, cell codes, requester ids and the arbiter
//             state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package maze_pkg;

   localparam int GRID_W  = 24;
   localparam int GRID_H  = 24;
   localparam int ADDR_W  = 10;
   localparam int COORD_W = 5;
   localparam int CELL_W  = 3;

   typedef enum logic [2:0] {
      OCCUPIED      = 3'd0,
      AVAILABLE     = 3'd1,
      START         = 3'd2,
      END           = 3'd3,
      YOUR_POSITION = 3'd4,
      PLUS_FIVE     = 3'd5,
      MINUS_FIVE    = 3'd6
   } cell_e;

   localparam logic [1:0] REQ_CHK = 2'd0;
   localparam logic [1:0] REQ_WR  = 2'd1;
   localparam logic [1:0] REQ_DRW = 2'd2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/maze_addr_calc.sv
`default_nettype none
// ============================================================================
//  Module   : maze_addr_calc
//  Purpose  : Combinational (x,y) -> linear cell address with range check.
//  Ports    : i_x, i_y  - cell coordinates (5 bits each)
//             o_addr    - y*GRID_W + x (forced to 0 when out of range)
//             o_oob     - coordinates outside the grid
//  Revision : 1.0 - initial release
// ============================================================================
module maze_addr_calc #(
   parameter int GRID_W = 24,
   parameter int GRID_H = 24
) (
   input  logic [4:0] i_x,
   input  logic [4:0] i_y,
   output logic [9:0] o_addr,
   output logic       o_oob
);
   import maze_pkg::*;

   localparam logic [COORD_W-1:0] c_grid_w = COORD_W'(GRID_W);
   localparam logic [COORD_W-1:0] c_grid_h = COORD_W'(GRID_H);

   logic [ADDR_W-1:0] w_x_ext;
   logic [ADDR_W-1:0] w_y_ext;
   logic [ADDR_W-1:0] w_row_base;

   assign w_x_ext = {{(ADDR_W-COORD_W){1'b0}}, i_x};
   assign w_y_ext = {{(ADDR_W-COORD_W){1'b0}}, i_y};

   // The native 24-wide board uses y*16 + y*8 so no multiplier is built.
   generate
      if (GRID_W == 24) begin : g_shift_mul
         assign w_row_base = (w_y_ext << 4) + (w_y_ext << 3);
      end else begin : g_const_mul
         assign w_row_base = w_y_ext * ADDR_W'(GRID_W);
      end
   endgenerate

   assign o_oob  = (i_x >= c_grid_w) || (i_y >= c_grid_h);
   // Never present an address built from out-of-range coordinates.
   assign o_addr = o_oob ? '0 : (w_row_base + w_x_ext);

endmodule
`default_nettype wire

// File: rtl/maze_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : maze_ram_arbiter
//  Purpose  : Single-port maze RAM arbiter for the move checker (read), the
//             position updater (write) and the board renderer (read), with
//             an aging counter that forces a renderer grant after MAX_WAIT.
//  Ports    : clock, resetn             - clock, sync active-low reset
//             i_chk_*/o_chk_*           - checker read port
//             i_wr_*/o_wr_ack           - updater write port
//             i_drw_*/o_drw_*           - renderer read port
//             o_oob_err                 - pulses with ack on bad coordinates
//             o_busy                    - arbiter not idle
//             o_mem_*/i_mem_rdata       - RAM interface
//  Revision : 1.0 - initial release
// ============================================================================
module maze_ram_arbiter #(
   parameter int GRID_W       = 24,
   parameter int GRID_H       = 24,
   parameter int READ_LATENCY = 1,
   parameter int MAX_WAIT     = 8
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       i_chk_req,
   input  logic [4:0] i_chk_x,
   input  logic [4:0] i_chk_y,
   output logic       o_chk_ack,
   output logic [2:0] o_chk_rdata,
   input  logic       i_wr_req,
   input  logic [4:0] i_wr_x,
   input  logic [4:0] i_wr_y,
   input  logic [2:0] i_wr_data,
   output logic       o_wr_ack,
   input  logic       i_drw_req,
   input  logic [4:0] i_drw_x,
   input  logic [4:0] i_drw_y,
   output logic       o_drw_ack,
   output logic [2:0] o_drw_rdata,
   output logic       o_oob_err,
   output logic       o_busy,
   output logic [9:0] o_mem_addr,
   output logic       o_mem_wren,
   output logic [2:0] o_mem_wdata,
   input  logic [2:0] i_mem_rdata
);
   import maze_pkg::*;

   localparam int AGE_W  = $clog2(MAX_WAIT + 1);
   localparam int WCNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [AGE_W-1:0]  c_age_max  = AGE_W'(MAX_WAIT);
   localparam logic [WCNT_W-1:0] c_wait_end = WCNT_W'(READ_LATENCY - 1);

   logic [1:0]        r_state;
   logic [1:0]        r_id;
   logic              r_oob;
   logic [WCNT_W-1:0] r_wait_cnt;
   logic [AGE_W-1:0]  r_age;
   logic [9:0]        r_mem_addr;
   logic [2:0]        r_mem_wdata;
   logic [2:0]        r_chk_rdata;
   logic [2:0]        r_drw_rdata;

   logic              w_any_req;
   logic              w_force_drw;
   logic [1:0]        w_win_id;
   logic [4:0]        w_sel_x;
   logic [4:0]        w_sel_y;
   logic [9:0]        w_addr;
   logic              w_oob;
   logic              w_drw_grant;

   always_comb begin
      w_any_req   = i_chk_req | i_wr_req | i_drw_req;
      w_force_drw = i_drw_req && (r_age == c_age_max);
      if (w_force_drw)   w_win_id = REQ_DRW;
      else if (i_chk_req) w_win_id = REQ_CHK;
      else if (i_wr_req)  w_win_id = REQ_WR;
      else                w_win_id = REQ_DRW;
      case (w_win_id)
         REQ_CHK: begin w_sel_x = i_chk_x; w_sel_y = i_chk_y; end
         REQ_WR:  begin w_sel_x = i_wr_x;  w_sel_y = i_wr_y;  end
         default: begin w_sel_x = i_drw_x; w_sel_y = i_drw_y; end
      endcase
      w_drw_grant = (r_state == S_IDLE) && w_any_req && (w_win_id == REQ_DRW);
   end

   maze_addr_calc #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_addr_calc (
      .i_x    (w_sel_x),
      .i_y    (w_sel_y),
      .o_addr (w_addr),
      .o_oob  (w_oob)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_id        <= REQ_CHK;
         r_oob       <= 1'b0;
         r_wait_cnt  <= '0;
         r_age       <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_chk_rdata <= '0;
         r_drw_rdata <= '0;
      end else begin
         // Age counts every cycle the renderer is left waiting, in any state.
         if (!i_drw_req || w_drw_grant)
            r_age <= '0;
         else if (r_age != c_age_max)
            r_age <= r_age + 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_id  <= w_win_id;
                  r_oob <= w_oob;
                  if (w_oob) begin
                     // Out-of-range reads report OCCUPIED; RAM is untouched.
                     r_state <= S_ACK;
                     if (w_win_id == REQ_CHK)      r_chk_rdata <= OCCUPIED;
                     else if (w_win_id == REQ_DRW) r_drw_rdata <= OCCUPIED;
                  end else begin
                     r_state    <= S_ISSUE;
                     r_mem_addr <= w_addr;
                     if (w_win_id == REQ_WR) r_mem_wdata <= i_wr_data;
                  end
               end
            end
            S_ISSUE: begin
               r_wait_cnt <= '0;
               r_state    <= (r_id == REQ_WR) ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
               if (r_wait_cnt == c_wait_end) begin
                  if (r_id == REQ_CHK) r_chk_rdata <= i_mem_rdata;
                  else                 r_drw_rdata <= i_mem_rdata;
                  r_state <= S_ACK;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            S_ACK: begin
               r_oob   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Acks are decoded from the single ACK state, so at most one is ever high.
   assign o_chk_ack   = (r_state == S_ACK) && (r_id == REQ_CHK);
   assign o_wr_ack    = (r_state == S_ACK) && (r_id == REQ_WR);
   assign o_drw_ack   = (r_state == S_ACK) && (r_id == REQ_DRW);
   assign o_oob_err   = (r_state == S_ACK) && r_oob;
   assign o_busy      = (r_state != S_IDLE);
   assign o_mem_wren  = (r_state == S_ISSUE) && (r_id == REQ_WR);
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_chk_rdata = r_chk_rdata;
   assign o_drw_rdata = r_drw_rdata;

endmodule
`default_nettype wire

// File: tb/tb_maze_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maze_ram_arbiter
//  Purpose  : Self-checking bench for maze_ram_arbiter with a behavioural
//             1-cycle-latency RAM and an ack scoreboard.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_maze_ram_arbiter;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       chk_req = 1'b0, wr_req = 1'b0, drw_req = 1'b0;
   logic [4:0] chk_x = '0, chk_y = '0, wr_x = '0, wr_y = '0, drw_x = '0, drw_y = '0;
   logic [2:0] wr_data = '0;
   logic       o_chk_ack, o_wr_ack, o_drw_ack, o_oob_err, o_busy, mem_wren;
   logic [2:0] o_chk_rdata, o_drw_rdata, mem_wdata;
   logic [9:0] mem_addr;
   logic [2:0] ram_q;
   logic       ram_init = 1'b1;
   logic [2:0] ram [0:575];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int         id;
      logic [2:0] rdata;
      logic       oob;
      int         c0;
      int         lat;
   } exp_t;
   exp_t sb[$];

   maze_ram_arbiter dut (
      .clock       (clock),
      .resetn      (resetn),
      .i_chk_req   (chk_req),
      .i_chk_x     (chk_x),
      .i_chk_y     (chk_y),
      .o_chk_ack   (o_chk_ack),
      .o_chk_rdata (o_chk_rdata),
      .i_wr_req    (wr_req),
      .i_wr_x      (wr_x),
      .i_wr_y      (wr_y),
      .i_wr_data   (wr_data),
      .o_wr_ack    (o_wr_ack),
      .i_drw_req   (drw_req),
      .i_drw_x     (drw_x),
      .i_drw_y     (drw_y),
      .o_drw_ack   (o_drw_ack),
      .o_drw_rdata (o_drw_rdata),
      .o_oob_err   (o_oob_err),
      .o_busy      (o_busy),
      .o_mem_addr  (mem_addr),
      .o_mem_wren  (mem_wren),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (ram_q)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Power-up contents of the RAM model (address 51 holds AVAILABLE).
   function automatic logic [2:0] seed(input int a);
      return (a == 51) ? 3'd1 : 3'(a % 7);
   endfunction

   always @(posedge clock) begin
      if (ram_init) begin
         for (int i = 0; i < 576; i++) ram[i] <= seed(i);
      end else if (mem_wren) begin
         ram[mem_addr] <= mem_wdata;
      end
      ram_q <= ram[mem_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input int id, input logic [2:0] rd, input logic oob,
                               input int c0, input int lat);
      exp_t e;
      e.id = id; e.rdata = rd; e.oob = oob; e.c0 = c0; e.lat = lat;
      return e;
   endfunction

   // Ack monitor / scoreboard checker.
   int   mon_n;
   int   mon_id;
   exp_t mon_e;
   always @(negedge clock) begin
      if (resetn) begin
         mon_n = int'(o_chk_ack) + int'(o_wr_ack) + int'(o_drw_ack);
         if (mon_n > 0) begin
            check_eq("one_ack", mon_n, 1);
            mon_id = o_chk_ack ? 0 : (o_wr_ack ? 1 : 2);
            if (sb.size() == 0) begin
               check_eq("unexpected_ack", mon_id, 99);
            end else begin
               mon_e = sb.pop_front();
               check_eq("ack_id", mon_id, mon_e.id);
               check_eq("oob_err", o_oob_err, mon_e.oob);
               if (mon_e.id == 0)      check_eq("chk_rdata", o_chk_rdata, mon_e.rdata);
               else if (mon_e.id == 2) check_eq("drw_rdata", o_drw_rdata, mon_e.rdata);
               if (mon_e.lat >= 0)     check_eq("ack_latency", cyc - mon_e.c0, mon_e.lat);
            end
         end else if (o_oob_err) begin
            check_eq("stray_oob", 1, 0);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int id, input logic on, input int x, input int y, input logic [2:0] d);
      case (id)
         0: begin chk_req = on; chk_x = 5'(x); chk_y = 5'(y); end
         1: begin wr_req = on; wr_x = 5'(x); wr_y = 5'(y); wr_data = d; end
         default: begin drw_req = on; drw_x = 5'(x); drw_y = 5'(y); end
      endcase
   endtask

   task automatic wait_ack(input int id, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clock);
         case (id)
            0: seen = o_chk_ack;
            1: seen = o_wr_ack;
            default: seen = o_drw_ack;
         endcase
      end
      if (!seen) check_eq("ack_timeout", id, 99);
      case (id)
         0: chk_req = 1'b0;
         1: wr_req  = 1'b0;
         default: drw_req = 1'b0;
      endcase
   endtask

   int c0;
   int n_ack;

   initial begin
      repeat (3) tick();
      @(negedge clock);
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_acks", {o_chk_ack, o_wr_ack, o_drw_ack, o_oob_err}, 0);
      check_eq("rst_wren", mem_wren, 0);
      check_eq("rst_addr", mem_addr, 0);
      check_eq("rst_wdata", mem_wdata, 0);
      check_eq("rst_rdata", {o_chk_rdata, o_drw_rdata}, 0);
      resetn = 1'b1;
      ram_init = 1'b0;
      repeat (2) tick();

      // Checker read of (3,2) -> address 51.
      tick(); c0 = cyc;
      sb.push_back(mk(0, 3'd1, 1'b0, c0, 3));
      set_req(0, 1'b1, 3, 2, 3'd0);
      @(negedge clock);
      @(negedge clock);
      check_eq("rd_addr", mem_addr, 51);
      check_eq("rd_wren", mem_wren, 0);
      wait_ack(0, 10);

      // Write of the last cell (23,23) -> address 575.
      tick(); c0 = cyc;
      sb.push_back(mk(1, 3'd0, 1'b0, c0, 2));
      set_req(1, 1'b1, 23, 23, 3'd4);
      @(negedge clock);
      check_eq("wr_wren_idle", mem_wren, 0);
      @(negedge clock);
      check_eq("wr_addr", mem_addr, 575);
      check_eq("wr_wren", mem_wren, 1);
      check_eq("wr_wdata", mem_wdata, 4);
      wait_ack(1, 10);
      check_eq("wr_wren_done", mem_wren, 0);
      check_eq("ram_575", ram[575], 4);

      // Checker read with x out of range.
      tick(); c0 = cyc;
      sb.push_back(mk(0, 3'd0, 1'b1, c0, 1));
      set_req(0, 1'b1, 24, 0, 3'd0);
      wait_ack(0, 10);
      check_eq("oob_addr_kept", mem_addr, 575);
      check_eq("oob_wren", mem_wren, 0);

      // All three requesters in the same cycle.
      tick(); c0 = cyc;
      sb.push_back(mk(0, seed(25), 1'b0, c0, 3));
      sb.push_back(mk(1, 3'd0, 1'b0, c0, 6));
      sb.push_back(mk(2, seed(75), 1'b0, c0, 10));
      set_req(0, 1'b1, 1, 1, 3'd0);
      set_req(1, 1'b1, 2, 2, 3'd5);
      set_req(2, 1'b1, 3, 3, 3'd0);
      fork
         wait_ack(0, 20);
         wait_ack(1, 20);
         wait_ack(2, 20);
      join
      check_eq("ram_50", ram[50], 5);

      // Renderer read with y out of range.
      tick(); c0 = cyc;
      sb.push_back(mk(2, 3'd0, 1'b1, c0, 1));
      set_req(2, 1'b1, 0, 24, 3'd0);
      wait_ack(2, 10);

      // Aging: checker and renderer held continuously.
      tick(); c0 = cyc;
      sb.push_back(mk(0, seed(0), 1'b0, c0, 3));
      sb.push_back(mk(0, seed(0), 1'b0, c0, 7));
      sb.push_back(mk(2, seed(47), 1'b0, c0, 11));
      sb.push_back(mk(0, seed(0), 1'b0, c0, 15));
      set_req(0, 1'b1, 0, 0, 3'd0);
      set_req(2, 1'b1, 23, 1, 3'd0);
      n_ack = 0;
      for (int k = 0; k < 40 && n_ack < 4; k++) begin
         @(negedge clock);
         if (o_chk_ack || o_drw_ack) n_ack++;
      end
      chk_req = 1'b0;
      drw_req = 1'b0;
      check_eq("aging_acks", n_ack, 4);

      // Reset during the ISSUE cycle of a write.
      tick(); c0 = cyc;
      set_req(1, 1'b1, 5, 5, 3'd6);
      @(negedge clock);
      @(negedge clock);
      check_eq("rst_wr_wren", mem_wren, 1);
      check_eq("rst_wr_addr", mem_addr, 125);
      resetn = 1'b0;
      @(negedge clock);
      check_eq("rst_wr_wren_off", mem_wren, 0);
      check_eq("rst_wr_noack", o_wr_ack, 0);
      check_eq("rst_wr_busy", o_busy, 0);
      resetn = 1'b1;
      sb.push_back(mk(1, 3'd0, 1'b0, cyc, 2));
      wait_ack(1, 10);
      check_eq("ram_125", ram[125], 6);

      repeat (6) tick();
      check_eq("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
